// File: rtl/wb_bus_arbiter.sv
// Wishbone B4 classic master shared between instruction fetch (I) and load/store (D).
// One transaction at a time, D has priority. A watchdog ends accesses the slave never
// answers. A pipeline flush cancels the fetch response but lets the bus cycle finish.
//
// state  | meaning
// IDLE   | no bus cycle open, arbitrating between requesters
// I_ACC  | fetch access in flight, waiting for ack/err/timeout
// D_ACC  | load/store access in flight, waiting for ack/err/timeout
module wb_bus_arbiter #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  input  logic        flush_i,
  output logic        if_stall_o,
  output logic        mem_stall_o,
  output logic        bus_err_o,
  output logic        err_src_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  state_t               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          dat_q, dat_d;
  logic [31:0]          i_rdata_q, i_rdata_d;
  logic [31:0]          d_rdata_q, d_rdata_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic                 bus_err_q, bus_err_d;
  logic                 err_src_q, err_src_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 drop_q, drop_d;

  logic [TIMEOUT_W-1:0] wdog_inc;
  logic                 timed_out;
  logic                 done;
  logic                 fail;

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    err_src_d = err_src_q;
    wdog_d    = wdog_q;
    drop_d    = drop_q;
    wdog_inc  = wdog_q + TIMEOUT_W'(1);
    timed_out = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    case (state_q)
      IDLE: begin
        // A requester acked last cycle still holds req; masking it avoids a repeat access.
        if (d_req_i && !d_ack_q) begin
          state_d = D_ACC;
          cyc_d   = 1'b1;
          we_d    = d_we_i;
          sel_d   = d_sel_i;
          adr_d   = d_addr_i;
          dat_d   = d_wdata_i;
          wdog_d  = '0;
          drop_d  = 1'b0;
        end else if (i_req_i && !i_ack_q) begin
          state_d = I_ACC;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = 4'hF;
          adr_d   = i_addr_i;
          dat_d   = '0;
          wdog_d  = '0;
          drop_d  = flush_i;
        end
      end
      I_ACC, D_ACC: begin
        // The counter reaching TIMEOUT on this cycle means the cycle has been open TIMEOUT cycles.
        timed_out = (wdog_inc == TIMEOUT_W'(TIMEOUT));
        done      = wb_err_i || wb_ack_i || timed_out;
        fail      = wb_err_i || (!wb_ack_i && timed_out);
        if (!done) begin
          wdog_d = wdog_inc;
          if (state_q == I_ACC && flush_i) drop_d = 1'b1;
        end else begin
          state_d   = IDLE;
          cyc_d     = 1'b0;
          bus_err_d = fail;
          if (fail) err_src_d = (state_q == D_ACC);
          if (state_q == D_ACC) begin
            d_ack_d   = 1'b1;
            d_rdata_d = (fail || we_q) ? 32'h0 : wb_dat_i;
          end else begin
            drop_d = 1'b0;
            // A flush on the completing cycle also cancels the response.
            if (!(drop_q || flush_i)) begin
              i_ack_d   = 1'b1;
              i_rdata_d = fail ? 32'h0 : wb_dat_i;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; synchronous reset clears everything, closing any open cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      err_src_q <= 1'b0;
      wdog_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
      err_src_q <= err_src_d;
      wdog_q    <= wdog_d;
      drop_q    <= drop_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = sel_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign i_ack_o     = i_ack_q;
  assign d_ack_o     = d_ack_q;
  assign bus_err_o   = bus_err_q;
  assign err_src_o   = err_src_q;
  assign if_stall_o  = i_req_i & ~i_ack_q;
  assign mem_stall_o = d_req_i & ~d_ack_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations, then random
// requesters and a random-latency slave, all checked every cycle against a transaction model.
module tb_wb_bus_arbiter;
  localparam int TIMEOUT_W = 8;
  localparam int TIMEOUT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i, d_req_i, d_we_i, flush_i;
  logic [31:0] i_addr_i, d_addr_i, d_wdata_i, wb_dat_i;
  logic [3:0]  d_sel_i;
  logic        wb_ack_i, wb_err_i;
  logic [31:0] i_rdata_o, d_rdata_o, wb_adr_o, wb_dat_o;
  logic        i_ack_o, d_ack_o, if_stall_o, mem_stall_o, bus_err_o, err_src_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .flush_i(flush_i), .if_stall_o(if_stall_o), .mem_stall_o(mem_stall_o),
    .bus_err_o(bus_err_o), .err_src_o(err_src_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Transaction-level model: one outstanding access, its owner, age and latched request.
  logic        m_busy, m_own_d, m_drop, m_we;
  int          m_age;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        e_i_ack, e_d_ack, e_err, e_src;
  logic [31:0] e_i_rdata, e_d_rdata;

  // Slave behaviour: kind 0=ack 1=err 2=ack+err 3=silent, after sl_wait wait states.
  int          sl_cnt, sl_wait, sl_kind;
  bit          sl_rand;
  logic [31:0] sl_rdata;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by the clock edge that just passed, using the inputs the DUT sampled.
  task automatic model_step();
    logic old_i_ack, old_d_ack, ended, bad;
    old_i_ack = e_i_ack;
    old_d_ack = e_d_ack;
    e_i_ack = 1'b0;
    e_d_ack = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_drop = 1'b0; e_src = 1'b0;
      e_i_rdata = 32'h0; e_d_rdata = 32'h0;
      return;
    end
    if (!m_busy) begin
      if (d_req_i && !old_d_ack) begin
        m_busy = 1'b1; m_own_d = 1'b1; m_age = 0; m_drop = 1'b0;
        m_adr = d_addr_i; m_sel = d_sel_i; m_we = d_we_i; m_dat = d_wdata_i;
      end else if (i_req_i && !old_i_ack) begin
        m_busy = 1'b1; m_own_d = 1'b0; m_age = 0; m_drop = flush_i;
        m_adr = i_addr_i; m_sel = 4'hF; m_we = 1'b0; m_dat = 32'h0;
      end
    end else begin
      m_age++;
      if (!m_own_d && flush_i) m_drop = 1'b1;
      ended = wb_err_i || wb_ack_i || (m_age == TIMEOUT);
      bad   = wb_err_i || (!wb_ack_i && m_age == TIMEOUT);
      if (ended) begin
        m_busy = 1'b0;
        e_err  = bad;
        if (bad) e_src = m_own_d;
        if (m_own_d) begin
          e_d_ack = 1'b1;
          e_d_rdata = (bad || m_we) ? 32'h0 : wb_dat_i;
        end else if (!m_drop) begin
          e_i_ack = 1'b1;
          e_i_rdata = bad ? 32'h0 : wb_dat_i;
        end
        m_drop = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk1("cyc", wb_cyc_o, m_busy);
    chk1("stb", wb_stb_o, m_busy);
    if (m_busy) begin
      chk32("adr", wb_adr_o, m_adr);
      chk32("sel", {28'h0, wb_sel_o}, {28'h0, m_sel});
      chk1("we", wb_we_o, m_we);
      chk32("dat_o", wb_dat_o, m_dat);
    end
    chk1("i_ack", i_ack_o, e_i_ack);
    chk1("d_ack", d_ack_o, e_d_ack);
    chk32("i_rdata", i_rdata_o, e_i_rdata);
    chk32("d_rdata", d_rdata_o, e_d_rdata);
    chk1("bus_err", bus_err_o, e_err);
    chk1("err_src", err_src_o, e_src);
    chk1("if_stall", if_stall_o, i_req_i & ~e_i_ack);
    chk1("mem_stall", mem_stall_o, d_req_i & ~e_d_ack);
  endtask

  task automatic slave();
    int r;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    if (!wb_cyc_o) begin
      sl_cnt = 0;
      return;
    end
    sl_cnt++;
    if (sl_cnt == 1 && sl_rand) begin
      r = $urandom_range(0, 15);
      sl_kind = (r == 0) ? 3 : (r == 1) ? 1 : (r == 2) ? 2 : 0;
      sl_wait = $urandom_range(0, 3);
    end
    wb_dat_i = sl_rand ? $urandom : sl_rdata;
    if (sl_cnt > sl_wait) begin
      case (sl_kind)
        0: wb_ack_i = 1'b1;
        1: wb_err_i = 1'b1;
        2: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
        default: ;
      endcase
    end
  endtask

  // One cycle: sample at the falling edge, update model, compare, then let the slave respond.
  task automatic tick();
    @(negedge clk);
    model_step();
    compare();
    slave();
  endtask

  task automatic new_d();
    d_we_i    = 1'($urandom_range(0, 1));
    d_sel_i   = 4'($urandom_range(0, 15));
    d_addr_i  = $urandom;
    d_wdata_i = $urandom;
  endtask

  initial begin
    bit got;
    rst = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; flush_i = 1'b0;
    i_addr_i = 32'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0; d_sel_i = 4'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    sl_cnt = 0; sl_wait = 0; sl_kind = 0; sl_rand = 1'b0; sl_rdata = 32'h0;
    m_age = 0; m_own_d = 1'b0; m_we = 1'b0; m_adr = 32'h0; m_dat = 32'h0; m_sel = 4'h0;
    e_i_ack = 1'b0; e_d_ack = 1'b0;

    // Reset state
    tick(); tick();
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk32("rst_adr", wb_adr_o, 32'h0);
    chk1("rst_err_src", err_src_o, 1'b0);
    rst = 1'b0;
    tick();

    // Single fetch, zero-wait slave
    sl_kind = 0; sl_wait = 0; sl_rdata = 32'h0000_0013;
    i_req_i = 1'b1; i_addr_i = 32'h0000_0100;
    #1 chk1("f_stall_c0", if_stall_o, 1'b1);
    tick();
    chk1("f_cyc_c1", wb_cyc_o, 1'b1);
    chk32("f_adr_c1", wb_adr_o, 32'h0000_0100);
    chk1("f_stall_c1", if_stall_o, 1'b1);
    tick();
    chk1("f_ack_c2", i_ack_o, 1'b1);
    chk32("f_rdata_c2", i_rdata_o, 32'h0000_0013);
    chk1("f_stall_c2", if_stall_o, 1'b0);
    i_req_i = 1'b0;
    tick();

    // Simultaneous I and D: D store goes first, then I, no repeated D access
    sl_rdata = 32'h0000_0093;
    d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF; d_addr_i = 32'h2000_0000;
    d_wdata_i = 32'hDEAD_BEEF; i_req_i = 1'b1; i_addr_i = 32'h0000_0104;
    tick();
    chk1("p_we", wb_we_o, 1'b1);
    chk32("p_adr_d", wb_adr_o, 32'h2000_0000);
    chk32("p_dat", wb_dat_o, 32'hDEAD_BEEF);
    tick();
    chk1("p_d_ack", d_ack_o, 1'b1);
    chk1("p_i_wait", i_ack_o, 1'b0);
    d_req_i = 1'b0;
    tick();
    chk32("p_adr_i", wb_adr_o, 32'h0000_0104);
    chk1("p_we_i", wb_we_o, 1'b0);
    tick();
    chk1("p_i_ack", i_ack_o, 1'b1);
    chk32("p_i_rdata", i_rdata_o, 32'h0000_0093);
    i_req_i = 1'b0;
    tick();

    // Byte store with three wait states
    sl_wait = 3;
    d_req_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'b0010; d_addr_i = 32'h2000_0002;
    d_wdata_i = 32'h0000_AB00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1("sb_cyc", wb_cyc_o, 1'b1);
      chk1("sb_stall", mem_stall_o, 1'b1);
    end
    chk1("sb_slave_ack", wb_ack_i, 1'b1);
    tick();
    chk1("sb_d_ack", d_ack_o, 1'b1);
    chk1("sb_cyc_off", wb_cyc_o, 1'b0);
    chk1("sb_stall_off", mem_stall_o, 1'b0);
    d_req_i = 1'b0;
    tick();

    // Load returning data, then a load the slave ignores (watchdog)
    sl_wait = 0; sl_rdata = 32'h55AA_55AA;
    d_req_i = 1'b1; d_we_i = 1'b0; d_sel_i = 4'hF; d_addr_i = 32'h2000_0010;
    tick(); tick();
    chk32("ld_rdata", d_rdata_o, 32'h55AA_55AA);
    d_req_i = 1'b0;
    tick();
    sl_kind = 3;
    d_req_i = 1'b1; d_addr_i = 32'h3000_0000;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      chk1("to_cyc", wb_cyc_o, 1'b1);
      chk1("to_no_ack", d_ack_o, 1'b0);
    end
    tick();
    chk1("to_cyc_off", wb_cyc_o, 1'b0);
    chk1("to_d_ack", d_ack_o, 1'b1);
    chk1("to_bus_err", bus_err_o, 1'b1);
    chk1("to_err_src", err_src_o, 1'b1);
    chk32("to_rdata", d_rdata_o, 32'h0);
    d_req_i = 1'b0;
    tick();
    chk1("to_err_pulse", bus_err_o, 1'b0);

    // Flush during a fetch: response dropped, redirected fetch served
    sl_kind = 0; sl_wait = 2; sl_rdata = 32'h0000_0517;
    i_req_i = 1'b1; i_addr_i = 32'h0000_0200;
    tick();
    chk32("fl_adr", wb_adr_o, 32'h0000_0200);
    flush_i = 1'b1; i_addr_i = 32'h0000_0300;
    tick();
    flush_i = 1'b0;
    tick();
    tick();
    chk1("fl_no_ack", i_ack_o, 1'b0);
    chk1("fl_cyc_off", wb_cyc_o, 1'b0);
    tick();
    chk1("fl_regrant", wb_cyc_o, 1'b1);
    chk32("fl_adr2", wb_adr_o, 32'h0000_0300);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = i_ack_o;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL fl_refetch_ack no i_ack_o within 10 cycles t=%0t", $time);
    end
    chk32("fl_rdata", i_rdata_o, 32'h0000_0517);
    i_req_i = 1'b0;
    tick();

    // ack and err together on a fetch: error wins
    sl_kind = 2; sl_wait = 0;
    i_req_i = 1'b1; i_addr_i = 32'h0000_0400;
    tick(); tick();
    chk1("ae_i_ack", i_ack_o, 1'b1);
    chk1("ae_bus_err", bus_err_o, 1'b1);
    chk1("ae_err_src", err_src_o, 1'b0);
    chk32("ae_rdata", i_rdata_o, 32'h0);
    i_req_i = 1'b0;
    tick();

    // Reset during a D access
    sl_kind = 3;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h2000_0020;
    tick();
    chk1("rd_cyc", wb_cyc_o, 1'b1);
    rst = 1'b1;
    tick();
    chk1("rd_cyc_off", wb_cyc_o, 1'b0);
    chk1("rd_no_ack", d_ack_o, 1'b0);
    rst = 1'b0; d_req_i = 1'b0;
    tick();
    chk1("rd_no_ack2", d_ack_o, 1'b0);
    tick();

    // Random traffic
    sl_rand = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      flush_i = 1'b0;
      if (i_ack_o) begin
        i_req_i = 1'($urandom_range(0, 1));
        i_addr_i = $urandom;
      end else if (!i_req_i && $urandom_range(0, 2) == 0) begin
        i_req_i = 1'b1;
        i_addr_i = $urandom;
      end else if (i_req_i && $urandom_range(0, 15) == 0) begin
        flush_i = 1'b1;
        i_addr_i = $urandom;
      end
      if (d_ack_o) begin
        d_req_i = 1'($urandom_range(0, 1));
        new_d();
      end else if (!d_req_i && $urandom_range(0, 3) == 0) begin
        d_req_i = 1'b1;
        new_d();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
